// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding, common
// keyboard command bytes and small helper functions.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StStop,
    StAck,
    StWaitRel
  } tx_state_e;

  localparam logic [7:0] Ps2CmdSetLeds = 8'hED;
  localparam logic [7:0] Ps2CmdReset   = 8'hFF;
  localparam logic [7:0] Ps2AckByte    = 8'hFA;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines plus a falling-edge
// detector on the synchronized clock. Lines reset to their idle (released) level so
// leaving reset never produces a spurious fall.
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   ps2_clk_i      raw PS/2 clock line (asynchronous)
//   ps2_dat_i      raw PS/2 data line (asynchronous)
//   clk_sync_o     synchronized clock line
//   dat_sync_o     synchronized data line
//   clk_fall_o     one-cycle pulse on a synchronized clock falling edge
module ps2_host_tx_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic clk_fall_o
);

  logic [1:0] clk_ff_q;
  logic [1:0] dat_ff_q;
  logic       clk_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_ff_q   <= 2'b11;
      dat_ff_q   <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
      dat_ff_q   <= {dat_ff_q[0], ps2_dat_i};
      clk_prev_q <= clk_ff_q[1];
    end
  end

  assign clk_sync_o = clk_ff_q[1];
  assign dat_sync_o = dat_ff_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one byte to the device: inhibits the bus,
// issues request-to-send, shifts data/parity/stop on device-generated clock falls and
// checks the device ACK. busy is meant to gate the keyboard receiver.
// The open-drain pad tie-off (line = oe ? 1'b0 : 1'bz) lives at chip top; this block
// only observes the lines and drives the output enables.
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   tx_data        byte to send, captured on accept
//   tx_valid       request, accepted when tx_valid & tx_ready
//   tx_ready       high only when idle
//   busy           high whenever not idle
//   done           one-cycle pulse: byte sent and ACK seen
//   error          one-cycle pulse: timeout or missing ACK
//   ps2_clk        raw PS/2 clock line
//   ps2_dat        raw PS/2 data line
//   ps2_clk_oe     1 = pull clock line low
//   ps2_dat_oe     1 = pull data line low
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned CntW = $clog2(max_u(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);

  tx_state_e       state_q, state_d;
  logic [8:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dat_oe_q, dat_oe_d;

  logic clk_s, dat_s, fall;
  logic accept, inhibit_done, in_frame, timeout_hit, ack_bad, rel_ok;

  ps2_host_tx_line_sync u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (ps2_clk),
    .ps2_dat_i  (ps2_dat),
    .clk_sync_o (clk_s),
    .dat_sync_o (dat_s),
    .clk_fall_o (fall)
  );

  assign accept       = tx_valid && (state_q == StIdle);
  assign inhibit_done = (state_q == StInhibit) && (cnt_q == CntW'(INHIBIT_CYCLES - 1));
  assign in_frame     = state_q inside {StShift, StStop, StAck, StWaitRel};
  assign rel_ok       = (state_q == StWaitRel) && clk_s && dat_s;
  assign ack_bad      = (state_q == StAck) && fall && dat_s;
  // A fall restarts the watchdog, and a clean release wins over a coincident timeout.
  assign timeout_hit  = in_frame && !fall && !rel_ok &&
                        (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept) state_d = StInhibit;
      StInhibit: if (inhibit_done) state_d = StReq;
      StReq:     state_d = StShift;
      StShift: begin
        if (timeout_hit)                   state_d = StIdle;
        else if (fall && bit_cnt_q == 4'd8) state_d = StStop;
      end
      StStop: begin
        if (timeout_hit) state_d = StIdle;
        else if (fall)   state_d = StAck;
      end
      StAck: begin
        if (timeout_hit) state_d = StIdle;
        else if (fall)   state_d = dat_s ? StIdle : StWaitRel;
      end
      StWaitRel: if (rel_ok || timeout_hit) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath next-state: shift register, bit counter, shared cycle counter, data drive
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    dat_oe_d  = dat_oe_q;

    if (accept) begin
      shift_d   = {odd_parity(tx_data), tx_data};
      bit_cnt_d = 4'd0;
    end

    if (state_d != state_q || (in_frame && fall)) begin
      cnt_d = '0;
    end else if (state_q == StInhibit || in_frame) begin
      cnt_d = cnt_q + CntW'(1);
    end

    // Start bit goes on the line together with request-to-send.
    if (inhibit_done) dat_oe_d = 1'b1;
    if (state_q == StShift && fall) begin
      dat_oe_d  = ~shift_q[bit_cnt_q];
      bit_cnt_d = bit_cnt_q + 4'd1;
    end
    if (state_q == StStop && fall) dat_oe_d = 1'b0;
    if (state_d == StIdle) dat_oe_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      dat_oe_q  <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      dat_oe_q  <= dat_oe_d;
    end
  end

  // Outputs; completion pulses are suppressed while reset is asserted.
  always_comb begin
    tx_ready   = (state_q == StIdle);
    busy       = (state_q != StIdle);
    ps2_clk_oe = (state_q == StInhibit) || (state_q == StReq);
    ps2_dat_oe = dat_oe_q;
    done       = rst_n && rel_ok;
    error      = rst_n && (timeout_hit || ack_bad);
  end

endmodule
